// File: rtl/nist_bitstream_gen_pkg.sv
// Shared mode codes, FSM state type and LFSR constants for the NIST test-bit generator.
package nist_bitstream_gen_pkg;

    localparam logic [2:0] MODE_ZERO = 3'd0;
    localparam logic [2:0] MODE_ONE  = 3'd1;
    localparam logic [2:0] MODE_ALT  = 3'd2;
    localparam logic [2:0] MODE_LFSR = 3'd3;
    localparam logic [2:0] MODE_BIAS = 3'd4;

    localparam logic [15:0] LFSR_RST_SEED = 16'hACE1;
    // Feedback taps at bits 0, 2, 3 and 5 of the right-shifting register
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    // The all-zero state locks the LFSR, so it is swapped for the reset seed.
    function automatic logic [15:0] effective_seed(input logic [15:0] seed);
        return (seed == 16'h0000) ? LFSR_RST_SEED : seed;
    endfunction

endpackage

// File: rtl/nist_bitstream_gen_if.sv
// Control and serial-output bundle between a frame requester and the bit generator.
interface nist_bitstream_gen_if #(
    parameter int unsigned SEQ_LEN = 128
);
    localparam int unsigned CNT_W = $clog2(SEQ_LEN + 1);

    logic             start;
    logic             abort;
    logic [2:0]       mode;
    logic [15:0]      seed;
    logic             rnd_out;
    logic             rnd_valid;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] ones_cnt;

    modport master (
        output start, abort, mode, seed,
        input  rnd_out, rnd_valid, busy, done, ones_cnt
    );

    modport slave (
        input  start, abort, mode, seed,
        output rnd_out, rnd_valid, busy, done, ones_cnt
    );

endinterface

// File: rtl/nist_bitstream_gen_lfsr16.sv
// 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1), right shift with feedback into bit 15.
module nist_bitstream_gen_lfsr16
    import nist_bitstream_gen_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        step,
    output logic [15:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= LFSR_RST_SEED;
        end else if (load) begin
            q <= seed;
        end else if (step) begin
            q <= {^(q & LFSR_TAPS), q[15:1]};
        end
    end

endmodule

// File: rtl/nist_bitstream_gen.sv
// Framed test-bit source: emits SEQ_LEN bits of a selected stream and counts the ones sent.
module nist_bitstream_gen
    import nist_bitstream_gen_pkg::*;
#(
    parameter int unsigned SEQ_LEN = 128
) (
    input  logic                clk,
    input  logic                rst,
    nist_bitstream_gen_if.slave bus
);

    localparam int unsigned      CNT_W    = $clog2(SEQ_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SEQ_LEN - 1);

    state_t           state;
    logic [2:0]       mode_q;
    logic [CNT_W-1:0] idx_q;
    logic [CNT_W-1:0] ones_q;
    logic             rnd_valid_q;
    logic             busy_q;
    logic             done_q;
    logic [15:0]      lfsr_q;
    logic [15:0]      lfsr_seed;
    logic             lfsr_step;
    logic             start_ok;
    logic             bit_sel;
    logic             unused_lfsr;

    // Abort outranks start when both arrive in IDLE.
    assign start_ok  = (state == S_IDLE) && bus.start && !bus.abort;
    assign lfsr_seed = effective_seed(bus.seed);
    assign lfsr_step = (state == S_RUN);

    nist_bitstream_gen_lfsr16 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (start_ok),
        .seed (lfsr_seed),
        .step (lfsr_step),
        .q    (lfsr_q)
    );

    assign unused_lfsr = ^lfsr_q[15:2];

    always_comb begin
        bit_sel = 1'b0;
        case (mode_q)
            MODE_ONE:  bit_sel = 1'b1;
            MODE_ALT:  bit_sel = idx_q[0];
            MODE_LFSR: bit_sel = lfsr_q[0];
            MODE_BIAS: bit_sel = lfsr_q[0] & lfsr_q[1];
            default:   bit_sel = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            mode_q      <= MODE_ZERO;
            idx_q       <= '0;
            ones_q      <= '0;
            rnd_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        state       <= S_RUN;
                        mode_q      <= bus.mode;
                        idx_q       <= '0;
                        ones_q      <= '0;
                        rnd_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                S_RUN: begin
                    // The bit on the line this cycle is counted even when aborting.
                    ones_q <= ones_q + CNT_W'(bit_sel);
                    idx_q  <= idx_q + CNT_W'(1);
                    if (bus.abort || (idx_q == LAST_IDX)) begin
                        state       <= bus.abort ? S_IDLE : S_DONE;
                        rnd_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        done_q      <= !bus.abort;
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    done_q <= 1'b0;
                end
                default: begin
                    state       <= S_IDLE;
                    rnd_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rnd_out   = rnd_valid_q & bit_sel;
    assign bus.rnd_valid = rnd_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.ones_cnt  = ones_q;

endmodule

// File: tb/tb_nist_bitstream_gen.sv
// Bench for nist_bitstream_gen: table of whole frames scored bit-by-bit, plus corner sequences.
module tb_nist_bitstream_gen;

    localparam int unsigned SEQ_LEN = 128;

    typedef struct {
        logic [2:0]  mode;
        logic [15:0] seed;
        int          lo;
        int          hi;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    nist_bitstream_gen_if #(.SEQ_LEN(SEQ_LEN)) bus ();

    nist_bitstream_gen #(.SEQ_LEN(SEQ_LEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic exp_q[$];
    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference stream built from the stream definitions; pushes every bit to the scoreboard.
    function automatic int model_frame(input logic [2:0] m, input logic [15:0] s);
        logic [15:0] l;
        logic        b;
        int          ones;
        l    = (s == 16'h0000) ? 16'hACE1 : s;
        ones = 0;
        for (int i = 0; i < int'(SEQ_LEN); i++) begin
            case (m)
                3'd1:    b = 1'b1;
                3'd2:    b = i[0];
                3'd3:    b = l[0];
                3'd4:    b = l[0] & l[1];
                default: b = 1'b0;
            endcase
            exp_q.push_back(b);
            if (b) ones++;
            l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
        end
        return ones;
    endfunction

    // Starts at a falling edge; returns one falling edge after the done pulse (or after abort).
    task automatic run_frame(input logic [2:0] m, input logic [15:0] s, input int abort_at,
                             input bit hold, output int ones_dut, output logic [15:0] head);
        int   ones_exp;
        int   ones_popped;
        int   nvalid;
        int   cyc;
        bit   got_done;
        bit   aborted;
        logic seen_bad;
        logic e;
        exp_q.delete();
        ones_exp    = model_frame(m, s);
        ones_popped = 0;
        nvalid      = 0;
        cyc         = 0;
        got_done    = 1'b0;
        aborted     = 1'b0;
        head        = '0;
        ones_dut    = 0;
        bus.mode    = m;
        bus.seed    = s;
        bus.start   = 1'b1;
        @(negedge clk);
        if (!hold) bus.start = 1'b0;
        bus.mode = ~m;
        bus.seed = ~s;
        while (!got_done && !aborted && cyc < int'(SEQ_LEN) + 8) begin
            if (bus.rnd_valid) begin
                if (nvalid == 0) chk("busy_first", bus.busy, 1);
                if (exp_q.size() > 0) e = exp_q.pop_front();
                else e = 1'bx;
                chk($sformatf("bit[%0d] mode%0d", nvalid, m), bus.rnd_out, e);
                if (e === 1'b1) ones_popped++;
                if (nvalid < 16) head[nvalid[3:0]] = bus.rnd_out;
                nvalid++;
                if (abort_at > 0 && nvalid == abort_at) begin
                    bus.abort = 1'b1;
                    @(negedge clk);
                    bus.abort = 1'b0;
                    aborted   = 1'b1;
                end
            end else if (bus.done) begin
                got_done = 1'b1;
            end
            if (!got_done && !aborted) begin
                @(negedge clk);
                cyc++;
            end
        end
        if (aborted) begin
            chk("abort_idle", {bus.rnd_valid, bus.busy, bus.done}, 0);
            chk("abort_partial_ones", bus.ones_cnt, ones_popped);
            ones_dut = int'(bus.ones_cnt);
            seen_bad = 1'b0;
            repeat (3) begin
                @(negedge clk);
                seen_bad = seen_bad | bus.done | bus.rnd_valid;
            end
            chk("abort_no_done", seen_bad, 0);
        end else begin
            chk("frame_len", nvalid, SEQ_LEN);
            chk("done_seen", got_done, 1);
            chk("done_no_valid", bus.rnd_valid, 0);
            @(negedge clk);
            chk("done_one_cycle", bus.done, 0);
            chk("ones_cnt", bus.ones_cnt, ones_exp);
            ones_dut = int'(bus.ones_cnt);
        end
        exp_q.delete();
        bus.mode = m;
        bus.seed = s;
    endtask

    initial begin
        #1ms;
        $display("FAIL global_timeout: simulation still running, limit 1ms");
        $fatal(1, "timeout");
    end

    initial begin
        int          ones;
        int          ones_b;
        logic [15:0] head;
        logic [15:0] head_b;

        vecs[0]  = '{3'd1, 16'h0001, 128, 128};
        vecs[1]  = '{3'd2, 16'h0002, 64, 64};
        vecs[2]  = '{3'd0, 16'h0003, 0, 0};
        vecs[3]  = '{3'd7, 16'h0004, 0, 0};
        vecs[4]  = '{3'd5, 16'h0005, 0, 0};
        vecs[5]  = '{3'd6, 16'h0006, 0, 0};
        vecs[6]  = '{3'd4, 16'h1111, 16, 48};
        vecs[7]  = '{3'd4, 16'h2222, 16, 48};
        vecs[8]  = '{3'd4, 16'h3333, 16, 48};
        vecs[9]  = '{3'd4, 16'h4444, 16, 48};
        vecs[10] = '{3'd4, 16'h5555, 16, 48};
        vecs[11] = '{3'd4, 16'h0F0F, 16, 48};
        vecs[12] = '{3'd4, 16'hBEEF, 16, 48};
        vecs[13] = '{3'd4, 16'h0000, 16, 48};

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.mode  = 3'd0;
        bus.seed  = 16'h0000;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {bus.rnd_out, bus.rnd_valid, bus.busy, bus.done, bus.ones_cnt}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Asynchronous reset in the middle of an LFSR frame
        bus.mode  = 3'd3;
        bus.seed  = 16'h1234;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (20) @(negedge clk);
        chk("running_before_rst", {bus.busy, bus.rnd_valid}, 2'b11);
        #2 rst = 1'b1;
        #1;
        chk("async_reset", {bus.rnd_out, bus.rnd_valid, bus.busy, bus.done, bus.ones_cnt}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        run_frame(3'd3, 16'h1234, 0, 1'b0, ones, head);

        for (int i = 0; i < 14; i++) begin
            run_frame(vecs[i].mode, vecs[i].seed, 0, 1'b0, ones, head);
            chk($sformatf("ones_range[%0d] got=%0d", i, ones),
                (ones >= vecs[i].lo) && (ones <= vecs[i].hi), 1);
        end

        // Seed 0 maps to ACE1; the first 16 LFSR bits are the seed shifted out LSB first
        run_frame(3'd3, 16'h0000, 0, 1'b0, ones, head);
        run_frame(3'd3, 16'hACE1, 0, 1'b0, ones_b, head_b);
        chk("lfsr_head_seed0", head, 16'hACE1);
        chk("lfsr_head_seed_ace1", head_b, 16'hACE1);
        chk("lfsr_seed0_same_ones", ones, ones_b);

        run_frame(3'd1, 16'h0000, 40, 1'b0, ones, head);
        chk("abort_at_40_ones", ones, 40);

        bus.mode  = 3'd1;
        bus.start = 1'b1;
        bus.abort = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_beats_start", {bus.busy, bus.rnd_valid, bus.done}, 0);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        @(negedge clk);

        // Start held high through RUN and DONE: the next frame begins only out of IDLE
        run_frame(3'd1, 16'h0000, 0, 1'b1, ones, head);
        chk("hold_idle_gap", {bus.busy, bus.rnd_valid, bus.done}, 0);
        @(negedge clk);
        chk("hold_restart", {bus.busy, bus.rnd_valid}, 2'b11);
        bus.start = 1'b0;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("hold_abort_idle", {bus.busy, bus.rnd_valid}, 0);
        chk("hold_abort_ones", bus.ones_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
